// File: rtl/fp_seq_pkg.sv
// Shared types and opcode constants for the FP multi-cycle sequencer.
// DIV_CODE / SQRT_CODE are also used by the FP ALU decoder.
package fp_seq_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAUNCH = 2'd1,
    WAIT   = 2'd2,
    WB     = 2'd3
  } seq_state_t;

  localparam logic [3:0] DIV_CODE  = 4'b0011;
  localparam logic [3:0] SQRT_CODE = 4'b0100;

  function automatic logic is_mc_op(input logic [3:0] c);
    return (c == DIV_CODE) || (c == SQRT_CODE);
  endfunction

endpackage

// File: rtl/fp_seq_timer.sv
// Watchdog cycle counter for an in-flight iterative FP op.
// Compiled only when FP_SEQ_WATCHDOG_EN is defined.
`ifdef FP_SEQ_WATCHDOG_EN
module fp_seq_timer #(
  parameter int MC_TIMEOUT = 64
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic inc,
  output logic expired
);

  localparam int W = (MC_TIMEOUT > 2) ? $clog2(MC_TIMEOUT) : 1;
  localparam logic [W-1:0] LIM = W'(MC_TIMEOUT - 1);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // clear on launch acceptance, count while the op is outstanding
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != LIM)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // counter register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign expired = (cnt_q == LIM);

endmodule
`endif

// File: rtl/fp_mc_sequencer.sv
// Schedules FP ops onto the fast ALU and the iterative div/sqrt unit.
// Optional watchdog: define FP_SEQ_WATCHDOG_EN.
module fp_mc_sequencer
  import fp_seq_pkg::*;
#(
  parameter int MC_TIMEOUT = 64
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       issue_valid,
  input  logic [3:0] fp_alu_ctrl,
  input  logic       fp_reg_write,
  input  logic [4:0] rs1,
  input  logic [4:0] rs2,
  input  logic [4:0] rd,
  output logic       stall,
  output logic       mc_start,
  output logic       mc_op,
  input  logic       mc_done,
  output logic       wb_en,
  output logic [4:0] wb_rd,
  output logic       wb_sel,
  output logic       busy,
  output logic       err_timeout
);

  seq_state_t state_q, state_d;
  logic       pend_v_q, pend_v_d;
  logic [4:0] pend_rd_q, pend_rd_d;
  logic       op_q, op_d;

  logic mc_op_in;
  logic raw_hz;
  logic accept;
  logic timeout;

  assign mc_op_in = issue_valid & is_mc_op(fp_alu_ctrl);

  assign raw_hz = pend_v_q & ((rs1 == pend_rd_q)
                | (rs2 == pend_rd_q)
                | (fp_reg_write & (rd == pend_rd_q)));

  // hazard stall: scoreboard hit, unit busy, or write-port conflict
  always_comb begin
    stall = issue_valid & (raw_hz
          | (mc_op_in & (state_q != IDLE))
          | ((state_q == WB) & fp_reg_write));
  end

  assign accept = mc_op_in & ~stall & (state_q == IDLE);

  // next state, scoreboard update and writeback mux
  always_comb begin
    state_d   = state_q;
    pend_v_d  = pend_v_q;
    pend_rd_d = pend_rd_q;
    op_d      = op_q;
    mc_start  = 1'b0;
    wb_en     = 1'b0;
    wb_sel    = 1'b0;
    wb_rd     = '0;
    if (issue_valid & ~mc_op_in & fp_reg_write & ~stall) begin
      wb_en = 1'b1;
      wb_rd = rd;
    end
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          state_d   = LAUNCH;
          pend_v_d  = 1'b1;
          pend_rd_d = rd;
          op_d      = (fp_alu_ctrl == SQRT_CODE);
        end
      end
      LAUNCH: begin
        mc_start = 1'b1;
        state_d  = WAIT;
      end
      WAIT: begin
        if (mc_done) begin
          state_d = WB;
        end else if (timeout) begin
          state_d  = IDLE;
          pend_v_d = 1'b0;
        end
      end
      WB: begin
        wb_en    = 1'b1;
        wb_sel   = 1'b1;
        wb_rd    = pend_rd_q;
        pend_v_d = 1'b0;
        state_d  = IDLE;
      end
    endcase
  end

  // FSM and scoreboard registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      pend_v_q  <= 1'b0;
      pend_rd_q <= '0;
      op_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      pend_v_q  <= pend_v_d;
      pend_rd_q <= pend_rd_d;
      op_q      <= op_d;
    end
  end

  assign mc_op = mc_start & op_q;
  assign busy  = (state_q != IDLE);

`ifdef FP_SEQ_WATCHDOG_EN
  logic expired;
  logic err_q, err_d;

  fp_seq_timer #(
    .MC_TIMEOUT(MC_TIMEOUT)
  ) u_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (accept),
    .inc    ((state_q == LAUNCH) | (state_q == WAIT)),
    .expired(expired)
  );

  assign timeout = (state_q == WAIT) & expired & ~mc_done;

  // sticky timeout flag
  always_comb begin
    err_d = err_q | timeout;
  end

  // error register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_q <= 1'b0;
    else        err_q <= err_d;
  end

  assign err_timeout = err_q;
`else
  localparam int unused_mc_timeout = MC_TIMEOUT;
  assign timeout     = 1'b0;
  assign err_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_fp_mc_sequencer.sv
// Directed bench for fp_mc_sequencer.
// Define FP_SEQ_WATCHDOG_EN to exercise the watchdog build.
module tb_fp_mc_sequencer;
  import fp_seq_pkg::*;

`ifdef FP_SEQ_WATCHDOG_EN
  localparam int TMO = 8;
  localparam int LAT = 6;
`else
  localparam int TMO = 64;
  localparam int LAT = 10;
`endif

  localparam logic [3:0] ADD = 4'b0000;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       issue_valid;
  logic [3:0] fp_alu_ctrl;
  logic       fp_reg_write;
  logic [4:0] rs1, rs2, rd;
  logic       stall, mc_start, mc_op, mc_done;
  logic       wb_en, wb_sel, busy, err_timeout;
  logic [4:0] wb_rd;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  fp_mc_sequencer #(
    .MC_TIMEOUT(TMO)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .issue_valid (issue_valid),
    .fp_alu_ctrl (fp_alu_ctrl),
    .fp_reg_write(fp_reg_write),
    .rs1         (rs1),
    .rs2         (rs2),
    .rd          (rd),
    .stall       (stall),
    .mc_start    (mc_start),
    .mc_op       (mc_op),
    .mc_done     (mc_done),
    .wb_en       (wb_en),
    .wb_rd       (wb_rd),
    .wb_sel      (wb_sel),
    .busy        (busy),
    .err_timeout (err_timeout)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input logic v,
                     input logic [3:0] c,
                     input logic w,
                     input logic [4:0] a,
                     input logic [4:0] b,
                     input logic [4:0] d,
                     input logic dn);
    @(posedge clk);
    #1;
    issue_valid  = v;
    fp_alu_ctrl  = c;
    fp_reg_write = w;
    rs1          = a;
    rs2          = b;
    rd           = d;
    mc_done      = dn;
    #1;
  endtask

  task automatic nop(input logic dn);
    cyc(1'b0, ADD, 1'b0, 5'd0, 5'd0, 5'd0, dn);
  endtask

  initial begin
    int n;
    rst_n        = 1'b0;
    issue_valid  = 1'b0;
    fp_alu_ctrl  = '0;
    fp_reg_write = 1'b0;
    rs1          = '0;
    rs2          = '0;
    rd           = '0;
    mc_done      = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_stall", stall, 0);
    chk("rst_start", mc_start, 0);
    chk("rst_wb_en", wb_en, 0);
    chk("rst_wb_rd", wb_rd, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", err_timeout, 0);
    #2 rst_n = 1'b1;

    // fast op retires in issue cycle
    cyc(1, ADD, 1, 5'd1, 5'd2, 5'd5, 0);
    chk("fadd_wb_en", wb_en, 1);
    chk("fadd_wb_sel", wb_sel, 0);
    chk("fadd_wb_rd", wb_rd, 5);
    chk("fadd_stall", stall, 0);

    // FDIV rd=3
    cyc(1, DIV_CODE, 1, 5'd1, 5'd2, 5'd3, 0);
    chk("div_iss_stall", stall, 0);
    chk("div_iss_wb", wb_en, 0);
    chk("div_iss_start", mc_start, 0);
    nop(0);
    chk("div_start", mc_start, 1);
    chk("div_op", mc_op, 0);
    chk("div_busy", busy, 1);
    cyc(1, ADD, 1, 5'd3, 5'd2, 5'd9, 0);
    chk("raw_stall", stall, 1);
    chk("raw_wb", wb_en, 0);
    chk("start_once", mc_start, 0);
    cyc(1, ADD, 1, 5'd7, 5'd6, 5'd8, 0);
    chk("ind_stall", stall, 0);
    chk("ind_wb_en", wb_en, 1);
    chk("ind_wb_rd", wb_rd, 8);
    chk("ind_wb_sel", wb_sel, 0);
    cyc(1, ADD, 1, 5'd1, 5'd2, 5'd3, 0);
    chk("waw_stall", stall, 1);
    chk("waw_wb", wb_en, 0);
    repeat (LAT - 4) nop(0);
    nop(1);
    chk("done_busy", busy, 1);
    chk("done_wb", wb_en, 0);
    nop(0);
    chk("wb_en", wb_en, 1);
    chk("wb_sel", wb_sel, 1);
    chk("wb_rd", wb_rd, 3);
    chk("wb_busy", busy, 1);
    nop(0);
    chk("post_busy", busy, 0);
    chk("post_wb", wb_en, 0);

    // stray mc_done in IDLE
    nop(1);
    nop(0);
    chk("stray_busy", busy, 0);
    chk("stray_wb", wb_en, 0);

    // FSQRT behind FDIV, then write-port conflict
    cyc(1, DIV_CODE, 1, 5'd1, 5'd2, 5'd10, 0);
    cyc(1, SQRT_CODE, 1, 5'd1, 5'd2, 5'd11, 0);
    chk("sq_l_start", mc_start, 1);
    chk("sq_l_stall", stall, 1);
    cyc(1, SQRT_CODE, 1, 5'd1, 5'd2, 5'd11, 0);
    chk("sq_w_stall", stall, 1);
    cyc(1, SQRT_CODE, 1, 5'd1, 5'd2, 5'd11, 1);
    chk("sq_d_stall", stall, 1);
    cyc(1, SQRT_CODE, 1, 5'd1, 5'd2, 5'd11, 0);
    chk("sq_wb_stall", stall, 1);
    chk("sq_wb_en", wb_en, 1);
    chk("sq_wb_rd", wb_rd, 10);
    cyc(1, SQRT_CODE, 1, 5'd1, 5'd2, 5'd11, 0);
    chk("sq_acc_stall", stall, 0);
    chk("sq_acc_wb", wb_en, 0);
    nop(1);
    chk("sq_start", mc_start, 1);
    chk("sq_op", mc_op, 1);
    nop(0);
    chk("launch_done_ign", busy, 1);
    chk("launch_done_wb", wb_en, 0);
    nop(1);
    cyc(1, ADD, 1, 5'd1, 5'd2, 5'd12, 0);
    chk("port_stall", stall, 1);
    chk("port_wb_sel", wb_sel, 1);
    chk("port_wb_rd", wb_rd, 11);
    cyc(1, ADD, 1, 5'd1, 5'd2, 5'd12, 0);
    chk("port_rel_stall", stall, 0);
    chk("port_rel_en", wb_en, 1);
    chk("port_rel_sel", wb_sel, 0);
    chk("port_rel_rd", wb_rd, 12);

    // reset during WAIT, then stray mc_done
    cyc(1, DIV_CODE, 1, 5'd1, 5'd2, 5'd4, 0);
    nop(0);
    nop(0);
    chk("r_wait_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    chk("r_async_busy", busy, 0);
    chk("r_async_start", mc_start, 0);
    #1 rst_n = 1'b1;
    nop(1);
    chk("r_done_wb", wb_en, 0);
    chk("r_done_busy", busy, 0);
    cyc(1, ADD, 1, 5'd4, 5'd2, 5'd4, 0);
    chk("r_pend_stall", stall, 0);
    chk("r_pend_wb_rd", wb_rd, 4);

    // missing mc_done
    cyc(1, DIV_CODE, 1, 5'd1, 5'd2, 5'd6, 0);
    nop(0);
    chk("to_start", mc_start, 1);
`ifdef FP_SEQ_WATCHDOG_EN
    n = 0;
    do begin
      nop(0);
      n++;
      if (wb_en) chk("to_no_wb", wb_en, 0);
    end while (busy && n < 20);
    chk("to_cycles", n, 8);
    chk("to_err", err_timeout, 1);
    chk("to_pend_stall", stall, 0);
    cyc(1, ADD, 1, 5'd6, 5'd2, 5'd6, 0);
    chk("to_pend_clr", stall, 0);
    nop(0);
    chk("to_sticky", err_timeout, 1);
`else
    n = 0;
    repeat (80) begin
      nop(0);
      if (busy) n++;
    end
    chk("hold_busy_cnt", n, 80);
    chk("hold_err", err_timeout, 0);
    nop(1);
    nop(0);
    chk("hold_wb_en", wb_en, 1);
    chk("hold_wb_rd", wb_rd, 6);
    nop(0);
    chk("hold_idle", busy, 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
